mips_perf_unit: RTL and testbench

MIPS_PERF_UNIT -- requirements
Module: mips_perf_unit

---
 rtl/mips_perf_unit.sv | 110 +++++++++++
 tb/tb_mips_perf_unit.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_perf_unit.sv
// Event-driven performance counters with sticky overflow and 1-cycle read.
// Optional snapshot shadows: define MIPS_PERF_SNAPSHOT_EN.
module mips_perf_unit #(
    parameter int NUM_CTR   = 4,
    parameter int CTR_WIDTH = 32,
    parameter int NUM_EVT   = 8,
    localparam int IDX_W = (NUM_CTR > 1) ? $clog2(NUM_CTR) : 1,
    localparam int EVT_W = (NUM_EVT > 1) ? $clog2(NUM_EVT) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_EVT-1:0] events,
    input  logic               cfg_we,
    input  logic [IDX_W-1:0]   cfg_idx,
    input  logic [EVT_W-1:0]   cfg_evsel,
    input  logic               cfg_en,
    input  logic               clr,
    input  logic               freeze,
`ifdef MIPS_PERF_SNAPSHOT_EN
    input  logic               snap,
`endif
    input  logic               rd_en,
    input  logic [4:0]         rd_idx,
    output logic [31:0]        rd_data,
    output logic               rd_valid,
    output logic [NUM_CTR-1:0] ovf
);

    logic [CTR_WIDTH-1:0] count [NUM_CTR];
    logic [EVT_W-1:0]     evsel [NUM_CTR];
    logic [NUM_CTR-1:0]   en;
    logic [NUM_CTR-1:0]   hit;
    logic [NUM_CTR-1:0]   wrap;
    logic [2**EVT_W-1:0]  ev_pad;
    logic                 cfg_ok;
    logic [31:0]          rd_sel;

`ifdef MIPS_PERF_SNAPSHOT_EN
    logic [CTR_WIDTH-1:0] shadow [NUM_CTR];
`endif

    // Pad so an evsel beyond NUM_EVT selects a constant-zero line.
    always_comb begin
        ev_pad = '0;
        ev_pad[NUM_EVT-1:0] = events;
    end

    always_comb begin
        for (int i = 0; i < NUM_CTR; i++) begin
            hit[i]  = en[i] & ~freeze & ev_pad[evsel[i]];
            wrap[i] = hit[i] & (&count[i]);
        end
    end

    assign cfg_ok = 32'(cfg_idx) < 32'(NUM_CTR);

    always_comb begin
        rd_sel = '0;
        for (int i = 0; i < NUM_CTR; i++) begin
            if (rd_idx == 5'(i)) begin
`ifdef MIPS_PERF_SNAPSHOT_EN
                rd_sel = 32'(shadow[i]);
`else
                rd_sel = 32'(count[i]);
`endif
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_CTR; i++) begin
                count[i] <= '0;
                evsel[i] <= EVT_W'(i % NUM_EVT);
                en[i]    <= 1'b0;
                ovf[i]   <= 1'b0;
`ifdef MIPS_PERF_SNAPSHOT_EN
                shadow[i] <= '0;
`endif
            end
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            for (int i = 0; i < NUM_CTR; i++) begin
                if (clr) begin
                    count[i] <= '0;
                    ovf[i]   <= 1'b0;
                end else if (hit[i]) begin
                    count[i] <= count[i] + 1'b1;
                    if (wrap[i])
                        ovf[i] <= 1'b1;
                end
`ifdef MIPS_PERF_SNAPSHOT_EN
                // Shadow captures the post-increment value of this edge.
                if (clr)
                    shadow[i] <= '0;
                else if (snap)
                    shadow[i] <= hit[i] ? count[i] + 1'b1 : count[i];
`endif
                if (cfg_we && cfg_ok && cfg_idx == IDX_W'(i)) begin
                    evsel[i] <= cfg_evsel;
                    en[i]    <= cfg_en;
                end
            end
            rd_valid <= rd_en;
            rd_data  <= rd_en ? rd_sel : '0;
        end
    end

endmodule

// File: tb/tb_mips_perf_unit.sv
// Randomized bench for mips_perf_unit (8-bit counters) against a cycle model.
// Covers directed scenarios plus random traffic; honours MIPS_PERF_SNAPSHOT_EN.
module tb_mips_perf_unit;

    localparam int NC = 4;
    localparam int CW = 8;
    localparam int NE = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  events;
    logic        cfg_we;
    logic [1:0]  cfg_idx;
    logic [2:0]  cfg_evsel;
    logic        cfg_en;
    logic        clr;
    logic        freeze;
    logic        snap;
    logic        rd_en;
    logic [4:0]  rd_idx;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic [3:0]  ovf;

    int n_chk = 0;
    int n_err = 0;

    int   m_cnt [NC];
    int   m_sh  [NC];
    int   m_ev  [NC];
    bit   m_en  [NC];
    logic [3:0]  m_ovf;
    logic        exp_rv;
    logic [31:0] exp_rd;

    mips_perf_unit #(
        .NUM_CTR  (NC),
        .CTR_WIDTH(CW),
        .NUM_EVT  (NE)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .events   (events),
        .cfg_we   (cfg_we),
        .cfg_idx  (cfg_idx),
        .cfg_evsel(cfg_evsel),
        .cfg_en   (cfg_en),
        .clr      (clr),
        .freeze   (freeze),
`ifdef MIPS_PERF_SNAPSHOT_EN
        .snap     (snap),
`endif
        .rd_en    (rd_en),
        .rd_idx   (rd_idx),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NC; i++) begin
            m_cnt[i] = 0;
            m_sh[i]  = 0;
            m_ev[i]  = i % NE;
            m_en[i]  = 1'b0;
        end
        m_ovf  = '0;
        exp_rv = 1'b0;
        exp_rd = '0;
    endtask

    task automatic model_step();
        int nc;
        bit h;
        exp_rv = rd_en;
        exp_rd = '0;
        if (rd_en && rd_idx < NC) begin
`ifdef MIPS_PERF_SNAPSHOT_EN
            exp_rd = m_sh[rd_idx];
`else
            exp_rd = m_cnt[rd_idx];
`endif
        end
        for (int i = 0; i < NC; i++) begin
            h  = m_en[i] && !freeze && events[m_ev[i]];
            nc = h ? (m_cnt[i] + 1) % (1 << CW) : m_cnt[i];
            if (h && m_cnt[i] == (1 << CW) - 1)
                m_ovf[i] = 1'b1;
`ifdef MIPS_PERF_SNAPSHOT_EN
            if (snap)
                m_sh[i] = nc;
`endif
            if (clr) begin
                m_cnt[i] = 0;
                m_ovf[i] = 1'b0;
                m_sh[i]  = 0;
            end else begin
                m_cnt[i] = nc;
            end
            if (cfg_we && cfg_idx == i) begin
                m_ev[i] = cfg_evsel;
                m_en[i] = cfg_en;
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
        chk("rd_valid", {31'b0, rd_valid}, {31'b0, exp_rv});
        if (exp_rv)
            chk("rd_data", rd_data, exp_rd);
        chk("ovf", {28'b0, ovf}, {28'b0, m_ovf});
    endtask

    task automatic idle();
        events = '0; cfg_we = 0; cfg_idx = '0; cfg_evsel = '0;
        cfg_en = 0; clr = 0; freeze = 0; snap = 0; rd_en = 0;
        rd_idx = '0;
    endtask

    task automatic ev_ticks(input logic [7:0] ev, input int n);
        events = ev;
        for (int k = 0; k < n; k++)
            tick();
        events = '0;
    endtask

    // Reads return shadows when snapshots exist, so refresh them first.
    task automatic read_ctr(input string tag, input logic [4:0] idx,
                            input logic [31:0] exp);
        events = '0;
`ifdef MIPS_PERF_SNAPSHOT_EN
        snap = 1; tick(); snap = 0;
`endif
        rd_en = 1; rd_idx = idx;
        tick();
        chk(tag, rd_data, exp);
        rd_en = 0;
    endtask

    initial begin
        idle();
        reset = 1'b1;
        #12;
        chk("rst_rv", {31'b0, rd_valid}, 32'd0);
        chk("rst_rd", rd_data, 32'd0);
        chk("rst_ovf", {28'b0, ovf}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        model_reset();

        // basic count of 5 events on counter 0 via event line 2
        cfg_we = 1; cfg_idx = 0; cfg_evsel = 2; cfg_en = 1;
        tick();
        cfg_we = 0;
        ev_ticks(8'h04, 5);
        read_ctr("cnt5", 0, 32'd5);
        tick();
        chk("rv_drop", {31'b0, rd_valid}, 32'd0);

        // wrap at 0xFF sets sticky ovf
        ev_ticks(8'h04, 250);
        chk("ovf_pre", {31'b0, ovf[0]}, 32'd0);
        ev_ticks(8'h04, 1);
        chk("ovf_set", {31'b0, ovf[0]}, 32'd1);
        read_ctr("wrap0", 0, 32'd0);
        ev_ticks(8'h04, 3);
        chk("ovf_sticky", {31'b0, ovf[0]}, 32'd1);
        clr = 1; tick(); clr = 0;
        chk("ovf_clr", {31'b0, ovf[0]}, 32'd0);

        // clr overrides a simultaneous event
        ev_ticks(8'h04, 2);
        events = 8'h04; clr = 1; tick(); clr = 0; events = 0;
        read_ctr("clr_win", 0, 32'd0);
        ev_ticks(8'h04, 1);
        read_ctr("after_clr", 0, 32'd1);

        // freeze blocks increments only
        clr = 1; tick(); clr = 0;
        freeze = 1;
        ev_ticks(8'h04, 3);
        freeze = 0;
        ev_ticks(8'h04, 2);
        read_ctr("freeze", 0, 32'd2);

        // out-of-range index and back-to-back reads
        rd_en = 1; rd_idx = 5'd20;
        tick();
        chk("oor_rv", {31'b0, rd_valid}, 32'd1);
        chk("oor_rd", rd_data, 32'd0);
        rd_idx = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("b2b_rv", {31'b0, rd_valid}, 32'd1);
        end
        rd_en = 0;

`ifdef MIPS_PERF_SNAPSHOT_EN
        clr = 1; tick(); clr = 0;
        ev_ticks(8'h04, 7);
        snap = 1; tick(); snap = 0;
        ev_ticks(8'h04, 3);
        rd_en = 1; rd_idx = 0;
        tick();
        chk("snap7", rd_data, 32'd7);
        rd_en = 0;
`endif

        // read in flight when reset asserts is dropped
        rd_en = 1; rd_idx = 0;
        @(posedge clk);
        #1 reset = 1'b1;
        rd_en = 0;
        #1;
        chk("rst_flight", {31'b0, rd_valid}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        tick();
        chk("post_rst_rv", {31'b0, rd_valid}, 32'd0);

        // random traffic
        for (int c = 0; c < 1500; c++) begin
            events    = 8'($urandom);
            cfg_we    = ($urandom_range(0, 7) == 0);
            cfg_idx   = 2'($urandom);
            cfg_evsel = 3'($urandom);
            cfg_en    = ($urandom_range(0, 3) != 0);
            clr       = ($urandom_range(0, 199) == 0);
            freeze    = ($urandom_range(0, 7) == 0);
            snap      = ($urandom_range(0, 7) == 0);
            rd_en     = $urandom_range(0, 1) == 1;
            rd_idx    = ($urandom_range(0, 9) == 0) ?
                        5'($urandom) : 5'($urandom_range(0, 4));
            tick();
        end
        idle();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
